// File: rtl/vga_grid_view.sv
// ----------------------------------------------------------------------------
// vga_grid_view
//   VGA raster generator for the Game-of-Life board. It draws a GRID_W x GRID_H
//   board of CELL_PX-square cells (alive = white, dead = black) and outlines the
//   edit cursor cell in red. The board and cursor are captured once per frame,
//   on the last pixel of the frame, so a frame is always drawn from one
//   consistent picture.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous, active-high reset
//   state        in   cell alive bits, cell (x,y) at bit y*GRID_W+x
//   cursor_x     in   cursor column, in cells
//   cursor_y     in   cursor row, in cells
//   r_out        out  red   (COLOR_W bits)
//   g_out        out  green (COLOR_W bits)
//   b_out        out  blue  (COLOR_W bits)
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   frame_start  out  one-cycle pulse in the cycle after a new snapshot
//
// Timing: colour and sync for raster position (col,row) reach the pins two
// clocks after the counters hold (col,row).
//
// Build option
//   CURSOR_BLINK_EN : when defined, the cursor outline blinks, changing phase
//                     every BLINK_FRAMES frames. When undefined the outline is
//                     always drawn and no frame counter exists.
// ----------------------------------------------------------------------------
module vga_grid_view #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned CELL_PX      = 20,
    parameter int unsigned GRID_W       = 32,
    parameter int unsigned GRID_H       = 24,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [GRID_W*GRID_H-1:0]   state,
    input  logic [7:0]                 cursor_x,
    input  logic [7:0]                 cursor_y,
    output logic [COLOR_W-1:0]         r_out,
    output logic [COLOR_W-1:0]         g_out,
    output logic [COLOR_W-1:0]         b_out,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CW      = 16;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL_PX - 1);
    localparam logic [CW-1:0] GW_C      = CW'(GRID_W);
    localparam logic [CW-1:0] GH_C      = CW'(GRID_H);

    if (CELL_PX < 3 || BLINK_FRAMES < 1) begin : g_param_check
        $error("vga_grid_view: CELL_PX must be >= 3 and BLINK_FRAMES >= 1");
    end

    // ------------------------------------------------------------------
    // Raster counters. sx/sy count pixels inside a cell, cx/cy count cells,
    // so the cell address needs no division.
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;

    always_comb begin
        col_d = col_q + 16'd1;
        row_d = row_q;
        sx_d  = sx_q + 16'd1;
        cx_d  = cx_q;
        sy_d  = sy_q;
        cy_d  = cy_q;
        if (sx_q == CELL_LAST) begin
            sx_d = '0;
            cx_d = cx_q + 16'd1;
        end
        if (col_q == H_LAST) begin
            col_d = '0;
            sx_d  = '0;
            cx_d  = '0;
            row_d = row_q + 16'd1;
            sy_d  = sy_q + 16'd1;
            if (sy_q == CELL_LAST) begin
                sy_d = '0;
                cy_d = cy_q + 16'd1;
            end
            if (row_q == V_LAST) begin
                row_d = '0;
                sy_d  = '0;
                cy_d  = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame snapshot, taken on the last pixel of the frame.
    // ------------------------------------------------------------------
    logic                     snap_evt;
    logic [GRID_W*GRID_H-1:0] snap_state_q, snap_state_d;
    logic [7:0]               snap_cx_q, snap_cx_d;
    logic [7:0]               snap_cy_q, snap_cy_d;
    logic                     frame_start_q, frame_start_d;

    always_comb begin
        snap_evt      = (col_q == H_LAST) && (row_q == V_LAST);
        snap_state_d  = snap_state_q;
        snap_cx_d     = snap_cx_q;
        snap_cy_d     = snap_cy_q;
        frame_start_d = snap_evt;
        if (snap_evt) begin
            snap_state_d = state;
            snap_cx_d    = cursor_x;
            snap_cy_d    = cursor_y;
        end
    end

    // ------------------------------------------------------------------
    // Cursor blink phase. The phase changes on the snapshot edge, so the new
    // phase already applies to the first pixel of the frame it belongs to.
    // ------------------------------------------------------------------
    logic cursor_on;

`ifdef CURSOR_BLINK_EN
    localparam int unsigned   BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (snap_evt) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign cursor_on = blink_q;
`else
    assign cursor_on = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Stage 1: visibility, cursor outline, alive bit, sync.
    // ------------------------------------------------------------------
    logic [GRID_W-1:0] row_bits;
    logic              alive;
    logic              active, in_grid, on_cursor, cell_edge;
    logic              s1_vis_q,   s1_vis_d;
    logic              s1_cur_q,   s1_cur_d;
    logic              s1_alive_q, s1_alive_d;
    logic              s1_hs_q,    s1_hs_d;
    logic              s1_vs_q,    s1_vs_d;

    // Alive bit is picked by a row mux then a column mux, keyed by the cell
    // counters; no address arithmetic on the pixel path.
    always_comb begin
        row_bits = '0;
        for (int unsigned y = 0; y < GRID_H; y++) begin
            if (cy_q == CW'(y)) row_bits = snap_state_q[y*GRID_W +: GRID_W];
        end
        alive = 1'b0;
        for (int unsigned x = 0; x < GRID_W; x++) begin
            if (cx_q == CW'(x)) alive = row_bits[x];
        end
    end

    always_comb begin
        active     = (col_q < H_ACT) && (row_q < V_ACT);
        // Cells beyond the active area are clipped by the active term.
        in_grid    = active && (cx_q < GW_C) && (cy_q < GH_C);
        // An off-board cursor never matches an in-grid cell, so it vanishes.
        on_cursor  = (cx_q == {8'h00, snap_cx_q}) && (cy_q == {8'h00, snap_cy_q});
        cell_edge  = (sx_q == '0) || (sx_q == CELL_LAST) ||
                     (sy_q == '0) || (sy_q == CELL_LAST);
        s1_vis_d   = in_grid;
        s1_cur_d   = in_grid && on_cursor && cell_edge && cursor_on;
        s1_alive_d = alive;
        s1_hs_d    = !((col_q >= HS_BEG) && (col_q < HS_END));
        s1_vs_d    = !((row_q >= VS_BEG) && (row_q < VS_END));
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select.
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, vs_q;

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s1_cur_q) begin
            r_d = '1;
        end else if (s1_vis_q && s1_alive_q) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            snap_state_q  <= '0;
            snap_cx_q     <= '0;
            snap_cy_q     <= '0;
            frame_start_q <= 1'b0;
            s1_vis_q      <= 1'b0;
            s1_cur_q      <= 1'b0;
            s1_alive_q    <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            snap_state_q  <= snap_state_d;
            snap_cx_q     <= snap_cx_d;
            snap_cy_q     <= snap_cy_d;
            frame_start_q <= frame_start_d;
            s1_vis_q      <= s1_vis_d;
            s1_cur_q      <= s1_cur_d;
            s1_alive_q    <= s1_alive_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= s1_hs_q;
            vs_q          <= s1_vs_q;
        end
    end

    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = frame_start_q;

endmodule
